alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/alu_sequencer_if.sv | 36 +++
 rtl/dec4to16.sv | 15 +
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode table, operation-class helpers and sequencer state encoding.
// Defining MULDIV_EN adds MUL/DIV to the legal opcode set.
package cpu_pkg;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

`ifdef MULDIV_EN
    localparam bit MULDIV_SUPPORTED = 1'b1;
`else
    localparam bit MULDIV_SUPPORTED = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        T_Y,
        T_ALU,
        T_WB,
        T_HI,
        T_ERR
    } seq_state_t;

    // Unary ops take their single operand from rb and skip the Y load.
    function automatic logic is_unary(input logic [4:0] opc);
        return (opc == OP_NEG) || (opc == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] opc);
        return MULDIV_SUPPORTED && ((opc == OP_MUL) || (opc == OP_DIV));
    endfunction

    function automatic logic is_legal(input logic [4:0] opc);
        logic legal;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL, OP_NEG, OP_NOT: legal = 1'b1;
            OP_MUL, OP_DIV:                          legal = MULDIV_SUPPORTED;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request and datapath-strobe bundle between the controller and the register/ALU datapath.
interface alu_sequencer_if;

    logic        start;
    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;

    logic [15:0] Rout;
    logic [15:0] Rin;
    logic        Yin;
    logic        Zlowin;
    logic        ZHighin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, opcode, ra, rb, rc,
        input  Rout, Rin, Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin,
        input  op, busy, done, err
    );

    modport slave (
        input  start, opcode, ra, rb, rc,
        output Rout, Rin, Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin,
        output op, busy, done, err
    );

endinterface

// File: rtl/dec4to16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module dec4to16 (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Control-step sequencer for one register-register ALU operation on a single-bus datapath.
// MULDIV_EN enables MUL/DIV and the T_HI write-back step; otherwise those opcodes are illegal.
module alu_sequencer
    import cpu_pkg::*;
(
    input logic            Clock,
    input logic            clear,
    alu_sequencer_if.slave bus
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [4:0]  opcode_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [3:0]  rc_q;
    logic        err_q;
    logic        accept;
    logic        rout_en;
    logic        rin_en;
    logic [3:0]  rout_sel;
    logic [15:0] rout_onehot;
    logic [15:0] rin_onehot;

    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are captured once at acceptance so the bus inputs may change mid-operation.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            opcode_q <= OP_NONE;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            opcode_q <= bus.opcode;
            ra_q     <= bus.ra;
            rb_q     <= bus.rb;
            rc_q     <= bus.rc;
            err_q    <= !is_legal(bus.opcode);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!is_legal(bus.opcode)) begin
                        state_next = T_ERR;
                    end else if (is_unary(bus.opcode)) begin
                        state_next = T_ALU;
                    end else begin
                        state_next = T_Y;
                    end
                end
            end
            T_Y:     state_next = T_ALU;
            T_ALU:   state_next = T_WB;
            T_WB:    state_next = is_muldiv(opcode_q) ? T_HI : IDLE;
`ifdef MULDIV_EN
            T_HI:    state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Strobes depend only on the state and the captured operands, never on live inputs.
    always_comb begin
        rout_en      = 1'b0;
        rout_sel     = rb_q;
        rin_en       = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zlowin   = 1'b0;
        bus.ZHighin  = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.op       = OP_NONE;
        bus.done     = 1'b0;
        case (state)
            T_Y: begin
                rout_en = 1'b1;
                bus.Yin = 1'b1;
            end
            T_ALU: begin
                rout_en     = 1'b1;
                rout_sel    = is_unary(opcode_q) ? rb_q : rc_q;
                bus.op      = opcode_q;
                bus.Zlowin  = 1'b1;
                bus.ZHighin = 1'b1;
            end
            T_WB: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv(opcode_q)) begin
                    bus.LOin = 1'b1;
                end else begin
                    rin_en   = 1'b1;
                    bus.done = 1'b1;
                end
            end
`ifdef MULDIV_EN
            T_HI: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
            end
`endif
            T_ERR: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    dec4to16 u_rout_dec (
        .idx    (rout_sel),
        .en     (rout_en),
        .onehot (rout_onehot)
    );

    dec4to16 u_rin_dec (
        .idx    (ra_q),
        .en     (rin_en),
        .onehot (rin_onehot)
    );

    assign bus.Rout = rout_onehot;
    assign bus.Rin  = rin_onehot;
    assign bus.busy = (state != IDLE);
    assign bus.err  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: per-cycle strobe traces from a step-list model plus
// a small register/ALU datapath driven by the DUT strobes to confirm operand routing.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic Clock = 1'b0;
    logic clear;

    alu_sequencer_if seq_if();

    alu_sequencer dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (seq_if)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic        yin;
        logic        zlowin;
        logic        zhighin;
        logic        zlowout;
        logic        zhighout;
        logic        hiin;
        logic        loin;
        logic [4:0]  op;
        logic        busy;
        logic        done;
        logic        err;
    } obs_t;

    typedef struct {
        logic [4:0]  opc;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        int          lat;
        logic        err;
        logic [15:0] rin;
    } vec_t;

    int total = 0;
    int bad   = 0;

    obs_t        exp_q[$];
    logic [31:0] regs [16];
    logic [31:0] y_reg, zlo, zhi, hi_reg, lo_reg;

    logic [4:0] op_pool [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01110,
                                 5'b01111, 5'b10000, 5'b10001};

    function automatic bit is_legal_op(input logic [4:0] opc);
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
            5'b01001, 5'b01010, 5'b01011, 5'b10000, 5'b10001: return 1'b1;
`ifdef MULDIV_EN
            5'b01110, 5'b01111: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] alu_ref(input logic [4:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] r;
        logic [63:0] dbl;
        logic [4:0]  s;
        r   = '0;
        s   = b[4:0];
        dbl = {a, a};
        case (opc)
            5'b00011: r[31:0] = a + b;
            5'b00100: r[31:0] = a - b;
            5'b00101: r[31:0] = a & b;
            5'b00110: r[31:0] = a | b;
            5'b00111: begin dbl = dbl >> s; r[31:0] = dbl[31:0];  end
            5'b01000: begin dbl = dbl << s; r[31:0] = dbl[63:32]; end
            5'b01001: r[31:0] = a >> s;
            5'b01010: r[31:0] = 32'($signed(a) >>> s);
            5'b01011: r[31:0] = a << s;
            5'b01110: r = {32'h0, a} * {32'h0, b};
            5'b01111: if (b != 32'h0) r = {a % b, a / b};
            5'b10000: r[31:0] = -b;
            5'b10001: r[31:0] = ~b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Expected per-cycle outputs: the step list for the opcode class, then one IDLE cycle.
    function automatic void build_expected(input logic [4:0] opc, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] c);
        obs_t r;
        bit   legal, unary, md;
        legal = is_legal_op(opc);
        unary = opc inside {5'b10000, 5'b10001};
        md    = legal && (opc inside {5'b01110, 5'b01111});
        exp_q.delete();
        if (!legal) begin
            r = '0; r.busy = 1'b1; r.done = 1'b1; r.err = 1'b1;
            exp_q.push_back(r);
        end else begin
            if (!unary) begin
                r = '0; r.rout = 16'h1 << b; r.yin = 1'b1; r.busy = 1'b1;
                exp_q.push_back(r);
            end
            r = '0; r.rout = 16'h1 << (unary ? b : c); r.op = opc;
            r.zlowin = 1'b1; r.zhighin = 1'b1; r.busy = 1'b1;
            exp_q.push_back(r);
            r = '0; r.zlowout = 1'b1; r.busy = 1'b1;
            if (md) begin
                r.loin = 1'b1;
                exp_q.push_back(r);
                r = '0; r.zhighout = 1'b1; r.hiin = 1'b1; r.busy = 1'b1; r.done = 1'b1;
                exp_q.push_back(r);
            end else begin
                r.rin = 16'h1 << a; r.done = 1'b1;
                exp_q.push_back(r);
            end
        end
        r = '0; r.err = !legal;
        exp_q.push_back(r);
    endfunction

    function automatic obs_t sample_now();
        obs_t o;
        o.rout = seq_if.Rout;     o.rin = seq_if.Rin;
        o.yin = seq_if.Yin;       o.zlowin = seq_if.Zlowin;     o.zhighin = seq_if.ZHighin;
        o.zlowout = seq_if.Zlowout; o.zhighout = seq_if.Zhighout;
        o.hiin = seq_if.HIin;     o.loin = seq_if.LOin;         o.op = seq_if.op;
        o.busy = seq_if.busy;     o.done = seq_if.done;         o.err = seq_if.err;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample mid-cycle and let the bench datapath react to the strobes of that cycle.
    task automatic applyStimulus(output obs_t o);
        logic [31:0] bus_v;
        logic [63:0] res;
        @(negedge Clock);
        o     = sample_now();
        bus_v = 32'h0;
        for (int i = 0; i < 16; i++) if (o.rout[i]) bus_v = regs[i];
        if (o.zlowout)  bus_v = zlo;
        if (o.zhighout) bus_v = zhi;
        res = alu_ref(o.op, y_reg, bus_v);
        if (o.yin)     y_reg = bus_v;
        if (o.zlowin)  zlo = res[31:0];
        if (o.zhighin) zhi = res[63:32];
        for (int i = 0; i < 16; i++) if (o.rin[i]) regs[i] = bus_v;
        if (o.loin) lo_reg = bus_v;
        if (o.hiin) hi_reg = bus_v;
    endtask

    task automatic checkOutput(input logic [4:0] opc, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input string tag, output int latency,
                               output logic [15:0] rin_seen, output logic err_seen);
        obs_t o;
        build_expected(opc, a, b, c);
        latency  = 0;
        rin_seen = '0;
        err_seen = 1'b0;
        seq_if.start  = 1'b1;
        seq_if.opcode = opc;
        seq_if.ra = a; seq_if.rb = b; seq_if.rc = c;
        for (int i = 0; i < exp_q.size(); i++) begin
            applyStimulus(o);
            if (i == 0) begin
                seq_if.start  = 1'b0;
                seq_if.opcode = 5'($urandom);
                seq_if.ra = 4'($urandom); seq_if.rb = 4'($urandom); seq_if.rc = 4'($urandom);
            end
            check_obs($sformatf("%s cycle%0d", tag, i + 1), o, exp_q[i]);
            rin_seen |= o.rin;
            if (o.done && latency == 0) begin
                latency  = i + 1;
                err_seen = o.err;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs [8];
        obs_t        o;
        obs_t        zero_obs;
        int          lat;
        logic [15:0] rin_seen;
        logic        err_seen;
        logic [8:0]  busy_v, done_v;
        int          yin_cnt;
        logic [31:0] old_regs [16];
        logic [63:0] expv;
        logic [4:0]  opc;
        logic [3:0]  a, b, c;
        int          diff;
        bit          unary, md;

        zero_obs = '0;
        clear = 1'b0;
        seq_if.start = 1'b0; seq_if.opcode = '0;
        seq_if.ra = '0; seq_if.rb = '0; seq_if.rc = '0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        y_reg = '0; zlo = '0; zhi = '0; hi_reg = '0; lo_reg = '0;
        regs[3] = 32'd12;
        regs[2] = 32'd5;
        regs[4] = 32'h0000_F0F0;

        applyStimulus(o);
        check_obs("reset outputs", o, zero_obs);
        clear = 1'b1;
        applyStimulus(o);
        applyStimulus(o);
        check_obs("idle outputs", o, zero_obs);

        vecs[0] = '{5'b00111, 4'd1,  4'd3,  4'd2,  3, 1'b0, 16'h0002};
        vecs[1] = '{5'b10001, 4'd5,  4'd4,  4'd0,  2, 1'b0, 16'h0020};
        vecs[2] = '{5'b11111, 4'd2,  4'd6,  4'd7,  1, 1'b1, 16'h0000};
        vecs[3] = '{5'b00011, 4'd9,  4'd9,  4'd9,  3, 1'b0, 16'h0200};
        vecs[4] = '{5'b10000, 4'd15, 4'd0,  4'd0,  2, 1'b0, 16'h8000};
`ifdef MULDIV_EN
        vecs[5] = '{5'b01110, 4'd6,  4'd3,  4'd2,  4, 1'b0, 16'h0000};
        vecs[6] = '{5'b01111, 4'd0,  4'd14, 4'd13, 4, 1'b0, 16'h0000};
`else
        vecs[5] = '{5'b01110, 4'd6,  4'd3,  4'd2,  1, 1'b1, 16'h0000};
        vecs[6] = '{5'b01111, 4'd0,  4'd14, 4'd13, 1, 1'b1, 16'h0000};
`endif
        vecs[7] = '{5'b00000, 4'd8,  4'd1,  4'd1,  1, 1'b1, 16'h0000};

        for (int v = 0; v < 8; v++) begin
            checkOutput(vecs[v].opc, vecs[v].ra, vecs[v].rb, vecs[v].rc,
                        $sformatf("vec%0d", v), lat, rin_seen, err_seen);
            check_val($sformatf("vec%0d latency", v), 64'(lat), 64'(vecs[v].lat));
            check_val($sformatf("vec%0d err", v), 64'(err_seen), 64'(vecs[v].err));
            check_val($sformatf("vec%0d rin", v), 64'(rin_seen), 64'(vecs[v].rin));
        end
        check_val("R1 = 12 ror 5", 64'(regs[1]), 64'h6000_0000);
        check_val("R5 = not R4", 64'(regs[5]), 64'hFFFF_0F0F);

        // Start held high across two operations: one idle cycle must separate them.
        seq_if.start = 1'b1; seq_if.opcode = 5'b00011;
        seq_if.ra = 4'd10; seq_if.rb = 4'd11; seq_if.rc = 4'd12;
        busy_v = '0; done_v = '0; yin_cnt = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            applyStimulus(o);
            if (cyc == 6) seq_if.start = 1'b0;
            busy_v = {busy_v[7:0], o.busy};
            done_v = {done_v[7:0], o.done};
            if (o.yin) yin_cnt++;
        end
        check_val("held start busy", 64'(busy_v), 64'(9'b111011100));
        check_val("held start done", 64'(done_v), 64'(9'b001000100));
        check_val("held start yin count", 64'(yin_cnt), 64'd2);

        // Reset mid-operation: outputs drop without a clock edge and the write is dropped.
        seq_if.start = 1'b1; seq_if.opcode = 5'b00011;
        seq_if.ra = 4'd7; seq_if.rb = 4'd1; seq_if.rc = 4'd2;
        applyStimulus(o);
        seq_if.start = 1'b0;
        applyStimulus(o);
        check_val("abort pre-reset rout", 64'(o.rout), 64'h0004);
        #2 clear = 1'b0;
        #1 o = sample_now();
        check_obs("async reset in T_ALU", o, zero_obs);
        repeat (2) @(negedge Clock);
        o = sample_now();
        check_obs("held reset", o, zero_obs);
        clear = 1'b1;
        rin_seen = '0;
        busy_v = '0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(o);
            rin_seen |= o.rin;
            busy_v = {busy_v[7:0], o.busy};
        end
        check_val("no rin after reset", 64'(rin_seen), 64'h0);
        check_val("no busy after reset", 64'(busy_v), 64'h0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) opc = 5'($urandom_range(0, 31));
            else opc = op_pool[$urandom_range(0, 12)];
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            old_regs = regs;
            unary = opc inside {5'b10000, 5'b10001};
            md    = is_legal_op(opc) && (opc inside {5'b01110, 5'b01111});
            checkOutput(opc, a, b, c, $sformatf("rand%0d op%b", n, opc), lat, rin_seen, err_seen);
            if (!is_legal_op(opc)) begin
                diff = 0;
                for (int i = 0; i < 16; i++) if (regs[i] !== old_regs[i]) diff++;
                check_val($sformatf("rand%0d illegal no write", n), 64'(diff), 64'h0);
            end else if (md) begin
                expv = alu_ref(opc, old_regs[b], old_regs[c]);
                check_val($sformatf("rand%0d hi:lo", n), {hi_reg, lo_reg}, expv);
            end else begin
                expv = unary ? alu_ref(opc, 32'h0, old_regs[b])
                             : alu_ref(opc, old_regs[b], old_regs[c]);
                check_val($sformatf("rand%0d R%0d", n, a), 64'(regs[a]), 64'(expv[31:0]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
